// File: rtl/matrix_scalar_divide.sv
// Serial PxP matrix / scalar divider in signed Q(N-Q).Q fixed point.
// One shared restoring divider produces one quotient bit per cycle.
// Elements are processed one after another into a result buffer.
// C is updated in a single step when the whole matrix is finished.
module matrix_scalar_divide #(
    parameter int N = 32,
    parameter int Q = 18,
    parameter int P = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [P*P*N-1:0] A,
    input  logic [N-1:0]     s,
    output logic [P*P*N-1:0] C,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int E  = P * P;
    localparam int W  = N + Q;
    localparam int CW = $clog2(W + 1);
    localparam int KW = (E > 1) ? $clog2(E) : 1;
    localparam logic [N-1:0] MAX_N = {1'b0, {(N-1){1'b1}}};

    typedef enum logic [2:0] {IDLE, LOAD, ITER, STORE, ZERO, DONE} state_t;

    state_t            state, state_nxt;
    logic [KW-1:0]     k;
    logic [CW-1:0]     cnt;
    logic [E*N-1:0]    a_q;
    logic [N-1:0]      s_q;
    logic              neg;
    logic [N-1:0]      abs_s;
    logic [N-1:0]      rem;
    logic [W-1:0]      dvd;
    logic [W-1:0]      quo;
    logic [N-1:0]      res_buf [E];

    logic signed [N-1:0] cur_elem;
    logic [N:0]        r_sh;
    logic              ge;
    logic [N-1:0]      r_new;
    logic              sat;
    logic [N-1:0]      res_val;

    // Magnitude of a two's complement value; -2^(N-1) maps onto 2^(N-1).
    function automatic logic [N-1:0] abs_val(input logic [N-1:0] v);
        return v[N-1] ? -v : v;
    endfunction

    // True when the magnitude quotient does not fit the positive range.
    function automatic logic sat_check(input logic [W-1:0] qm);
        return qm > {{Q{1'b0}}, MAX_N};
    endfunction

    // Clamp the magnitude quotient, then reapply the sign (symmetric range).
    function automatic logic [N-1:0] apply_sign(input logic [W-1:0] qm, input logic n);
        logic [N-1:0] mag;
        mag = sat_check(qm) ? MAX_N : qm[N-1:0];
        return n ? -mag : mag;
    endfunction

    // Result of x / 0: zero stays zero, anything else saturates by its sign.
    function automatic logic [N-1:0] zero_fill(input logic [N-1:0] a);
        if (a == '0) return '0;
        return a[N-1] ? -MAX_N : MAX_N;
    endfunction

    // Restoring divider step and per-element result formatting.
    always_comb begin
        cur_elem = a_q[int'(k)*N +: N];
        r_sh     = {rem, dvd[W-1]};
        ge       = r_sh >= {1'b0, abs_s};
        r_new    = ge ? N'(r_sh - {1'b0, abs_s}) : r_sh[N-1:0];
        sat      = sat_check(quo);
        res_val  = apply_sign(quo, neg);
    end

    // Next-state logic and status decode.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = (s == '0) ? ZERO : LOAD;
            LOAD:  state_nxt = ITER;
            ITER:  if (cnt == CW'(W - 1)) state_nxt = STORE;
            STORE: state_nxt = (k == KW'(E - 1)) ? DONE : LOAD;
            ZERO:  state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy = (state == LOAD) || (state == ITER) || (state == STORE) || (state == ZERO);
        done = (state == DONE);
    end

    // Control state, sticky flags and the published result matrix.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            k           <= '0;
            cnt         <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            C           <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    overflow    <= 1'b0;
                    div_by_zero <= 1'b0;
                    k           <= '0;
                end
                LOAD: cnt <= '0;
                ITER: cnt <= cnt + CW'(1);
                STORE: begin
                    if (sat) overflow <= 1'b1;
                    if (k == KW'(E - 1)) begin
                        for (int j = 0; j < E; j++)
                            C[j*N +: N] <= (j == int'(k)) ? res_val : res_buf[j];
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                ZERO: begin
                    overflow    <= 1'b1;
                    div_by_zero <= 1'b1;
                    for (int j = 0; j < E; j++)
                        C[j*N +: N] <= zero_fill(a_q[j*N +: N]);
                end
                default: ;
            endcase
        end
    end

    // Operand capture, divider datapath and result buffer.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (start) begin
                a_q <= A;
                s_q <= s;
            end
            LOAD: begin
                neg   <= cur_elem[N-1] ^ s_q[N-1];
                abs_s <= abs_val(s_q);
                dvd   <= {abs_val(cur_elem), {Q{1'b0}}};
                rem   <= '0;
                quo   <= '0;
            end
            ITER: begin
                rem <= r_new;
                dvd <= dvd << 1;
                quo <= {quo[W-2:0], ge};
            end
            STORE: res_buf[k] <= res_val;
            default: ;
        endcase
    end

endmodule
